project_button_ctrl: RTL and testbench

Debounce and edge-capture controller for the 4-bit push-button input port, exposed as an Avalon-MM slave to the Nios II. It synchronises the raw `in_port` pins, filters contact bounce with a per-bit stability counter, and latches qualifying edges into a capture register. It raises a maskable level interrupt from those latched edges. It replaces the bare read-only input port in the system and keeps the same address-0 data readback.

---
 rtl/project_button_ctrl.sv | 103 ++++++++++
 tb/tb_project_button_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/project_button_ctrl.sv
// Push-button debounce and edge-capture slave on Avalon-MM.
// Two-flop sync, per-bit stability counter, W1C edge latch, masked irq.
module project_button_ctrl #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [CNT_W-1:0] TERM =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_nxt;
  logic [WIDTH-1:0] imask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] edgecap_nxt;
  logic [WIDTH-1:0] cap;
  logic             pol;
  logic             wr_en;
  logic [31:0]      rd_nxt;
  logic [CNT_W-1:0] cnt     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt [WIDTH];
  logic             unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign unused_wd = ^writedata;

  always_comb begin
    stable_nxt = stable;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (sync2[i] != stable[i]) begin
        if (cnt[i] == TERM)
          stable_nxt[i] = sync2[i];
        else
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
      end
    end
  end

  // POL=0 latches presses (1->0), POL=1 latches releases (0->1)
  always_comb begin
    if (pol)
      cap = stable_nxt & ~stable;
    else
      cap = stable & ~stable_nxt;
    edgecap_nxt = edgecap;
    if (wr_en && address == 2'd2)
      edgecap_nxt = edgecap & ~writedata[WIDTH-1:0];
    edgecap_nxt = edgecap_nxt | cap;
  end

  always_comb begin
    rd_nxt = '0;
    unique case (address)
      2'd0: rd_nxt[WIDTH-1:0] = stable;
      2'd1: rd_nxt[WIDTH-1:0] = imask;
      2'd2: rd_nxt[WIDTH-1:0] = edgecap;
      2'd3: rd_nxt[0]         = pol;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= '1;
      sync2    <= '1;
      stable   <= '1;
      imask    <= '0;
      edgecap  <= '0;
      pol      <= 1'b0;
      readdata <= '0;
      for (int i = 0; i < WIDTH; i++)
        cnt[i] <= '0;
    end else begin
      sync1    <= in_port;
      sync2    <= sync1;
      stable   <= stable_nxt;
      edgecap  <= edgecap_nxt;
      readdata <= rd_nxt;
      for (int i = 0; i < WIDTH; i++)
        cnt[i] <= cnt_nxt[i];
      if (wr_en && address == 2'd1)
        imask <= writedata[WIDTH-1:0];
      if (wr_en && address == 2'd3)
        pol <= writedata[0];
    end
  end

  assign irq = |(edgecap & imask);

endmodule

// File: tb/tb_project_button_ctrl.sv
// Bench for project_button_ctrl: directed scenarios plus random
// traffic against a history-window reference model.
module tb_project_button_ctrl;

  localparam int W = 4;
  localparam int D = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [W-1:0] in_port = '1;
  logic        irq;

  int total = 0;
  int bad = 0;

  project_button_ctrl #(
    .WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  // reference: stable flips once sync2 disagreed on D consecutive edges
  logic [W-1:0] m_s1, m_s2, m_st, m_mask, m_ecap, m_nst, m_cap;
  logic         m_pol;
  logic [31:0]  m_rd;
  logic [W-1:0] hist [D];

  function automatic logic m_irq();
    return |(m_ecap & m_mask);
  endfunction

  function automatic logic will_flip(input int b);
    logic ok;
    ok = (m_s2[b] != m_st[b]);
    for (int k = 0; k < D - 1; k++)
      if (hist[k][b] == m_st[b]) ok = 1'b0;
    return ok;
  endfunction

  task automatic model_reset();
    m_s1 = '1; m_s2 = '1; m_st = '1;
    m_mask = '0; m_ecap = '0; m_pol = 1'b0; m_rd = '0;
    for (int k = 0; k < D; k++) hist[k] = '1;
  endtask

  task automatic model_step();
    case (address)
      2'd0: m_rd = {28'b0, m_st};
      2'd1: m_rd = {28'b0, m_mask};
      2'd2: m_rd = {28'b0, m_ecap};
      default: m_rd = {31'b0, m_pol};
    endcase
    for (int k = D - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = m_s2;
    m_nst = m_st;
    for (int i = 0; i < W; i++) begin
      logic all_diff;
      all_diff = 1'b1;
      for (int k = 0; k < D; k++)
        if (hist[k][i] == m_st[i]) all_diff = 1'b0;
      if (all_diff) m_nst[i] = ~m_st[i];
    end
    m_cap = m_pol ? (m_nst & ~m_st) : (m_st & ~m_nst);
    if (chipselect && !write_n) begin
      case (address)
        2'd1: m_mask = writedata[W-1:0];
        2'd2: m_ecap = m_ecap & ~writedata[W-1:0];
        2'd3: m_pol = writedata[0];
        default: ;
      endcase
    end
    m_ecap = m_ecap | m_cap;
    m_s2 = m_s1;
    m_s1 = in_port;
    m_st = m_nst;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_step();
    #1;
  endtask

  task automatic rd(input logic [1:0] a,
                    output logic [31:0] got,
                    output logic [31:0] exp);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    cyc();
    got = readdata;
    exp = m_rd;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0;
    writedata = d;
    cyc();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic test_reset();
    logic [31:0] got, exp;
    logic [31:0] req [4];
    req[0] = 32'hF; req[1] = 0; req[2] = 0; req[3] = 0;
    reset_n = 1'b0;
    model_reset();
    idle(2);
    total++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      $display("FAIL rst_hold rd=%h irq=%b exp 0/0", readdata, irq);
      bad++;
    end
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), got, exp);
      total++;
      if (got !== req[a] || got !== exp) begin
        $display("FAIL rst_read a=%0d got=%h exp=%h", a, got, req[a]);
        bad++;
      end
    end
    total++;
    if (irq !== 1'b0) begin
      $display("FAIL rst_irq got=%b exp=0", irq);
      bad++;
    end
  endtask

  task automatic test_press();
    logic [31:0] got, exp;
    int first;
    wr(2'd1, 32'h1);
    in_port = 4'hE;
    address = 2'd0; chipselect = 1'b0;
    first = 0;
    for (int n = 1; n <= 20; n++) begin
      cyc();
      total++;
      if (readdata !== m_rd) begin
        $display("FAIL press_data n=%0d got=%h exp=%h", n, readdata, m_rd);
        bad++;
      end
      if (readdata[0] === 1'b0 && first == 0) first = n;
    end
    // sync1, sync2, D debounce edges, then one read register edge
    total++;
    if (first != D + 3) begin
      $display("FAIL press_latency got=%0d exp=%0d", first, D + 3);
      bad++;
    end
    rd(2'd2, got, exp);
    total++;
    if (got !== 32'h1 || got !== exp) begin
      $display("FAIL press_ecap got=%h exp=%h", got, 32'h1);
      bad++;
    end
    total++;
    if (irq !== 1'b1) begin
      $display("FAIL press_irq got=%b exp=1", irq);
      bad++;
    end
    wr(2'd2, 32'h1);
    total++;
    if (irq !== 1'b0) begin
      $display("FAIL w1c_irq got=%b exp=0", irq);
      bad++;
    end
    rd(2'd2, got, exp);
    total++;
    if (got !== 32'h0 || got !== exp) begin
      $display("FAIL w1c_ecap got=%h exp=0", got);
      bad++;
    end
  endtask

  task automatic test_bounce();
    logic [31:0] got, exp;
    address = 2'd0; chipselect = 1'b0;
    for (int c = 0; c < 30 + D + 4; c++) begin
      in_port[1] = (c < 30 && ((c / 3) % 2) == 0) ? 1'b0 : 1'b1;
      cyc();
      total++;
      if (readdata[1] !== 1'b1 || readdata !== m_rd) begin
        $display("FAIL bounce_data c=%0d got=%h exp=%h", c, readdata, m_rd);
        bad++;
      end
    end
    rd(2'd2, got, exp);
    total++;
    if (got !== 32'h0 || got !== exp) begin
      $display("FAIL bounce_ecap got=%h exp=0", got);
      bad++;
    end
  endtask

  task automatic test_pol();
    logic [31:0] got, exp;
    wr(2'd3, 32'h1);
    in_port[2] = 1'b0;
    idle(D + 4);
    rd(2'd2, got, exp);
    total++;
    if (got !== 32'h0 || got !== exp) begin
      $display("FAIL pol_press got=%h exp=0", got);
      bad++;
    end
    in_port[2] = 1'b1;
    idle(D + 4);
    rd(2'd2, got, exp);
    total++;
    if (got !== 32'h4 || got !== exp) begin
      $display("FAIL pol_release got=%h exp=4", got);
      bad++;
    end
    wr(2'd2, 32'hF);
    wr(2'd3, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] got, exp;
    logic found;
    found = 1'b0;
    in_port[3] = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (will_flip(3)) begin
        wr(2'd2, 32'h8);
        found = 1'b1;
      end else begin
        cyc();
      end
    end
    total++;
    if (!found) begin
      $display("FAIL simul_timeout got=0 exp=1");
      bad++;
    end
    rd(2'd2, got, exp);
    total++;
    if (got !== 32'h8 || got !== exp) begin
      $display("FAIL simul_setwins got=%h exp=8", got);
      bad++;
    end
    in_port = 4'hF;
    idle(D + 4);
    wr(2'd2, 32'hF);
  endtask

  task automatic test_reset_mid();
    logic [31:0] got, exp;
    int first;
    in_port[0] = 1'b0;
    idle(7);
    reset_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      $display("FAIL midrst_clear rd=%h irq=%b exp 0/0", readdata, irq);
      bad++;
    end
    idle(2);
    reset_n = 1'b1;
    address = 2'd0; chipselect = 1'b0;
    first = 0;
    for (int n = 1; n <= 20; n++) begin
      cyc();
      total++;
      if (readdata !== m_rd) begin
        $display("FAIL midrst_data n=%0d got=%h exp=%h", n, readdata, m_rd);
        bad++;
      end
      if (readdata[0] === 1'b0 && first == 0) first = n;
    end
    total++;
    if (first != D + 3) begin
      $display("FAIL midrst_latency got=%0d exp=%0d", first, D + 3);
      bad++;
    end
    rd(2'd2, got, exp);
    total++;
    if (got !== 32'h1 || got !== exp) begin
      $display("FAIL midrst_ecap got=%h exp=1", got);
      bad++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(11) == 0) in_port[b] = ~in_port[b];
      address    = 2'($urandom_range(3));
      chipselect = 1'($urandom_range(1));
      write_n    = ($urandom_range(3) != 0);
      writedata  = $urandom;
      cyc();
      total++;
      if (readdata !== m_rd || irq !== m_irq()) begin
        $display("FAIL rand c=%0d rd=%h irq=%b exp=%h/%b",
                 c, readdata, irq, m_rd, m_irq());
        bad++;
      end
    end
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_pol();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
